bias_bank_ctrl: RTL and testbench

Double-buffered bias register bank with load/swap sequencing for the convolution output stage. The layer controller streams the next layer's per-output-channel biases (one word per handshake) into a shadow bank while the active bank keeps driving the bias-add datapath unchanged. A swap handshake copies the shadow bank to the active bank at a layer boundary. This block replaces the static per-channel bias source when biases change per layer.

---
 rtl/bias_bank_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bias_bank_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_bank_ctrl.sv
// bias_bank_ctrl: double-buffered per-channel bias bank.
// A new layer's biases stream into a shadow bank while the active bank keeps
// driving the bias-add datapath. A swap handshake copies shadow -> active.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   load_start_i/count_i   start a shadow load of count words (clamped to K)
//   bias_valid_i/data_i    bias stream in; bias_ready_o is the stream ready
//   load_done_o            pulse in the first cycle after the last word
//   load_err_o             pulse after a start with count 0 or count > K
//   busy_o                 high while a load is in progress or awaiting swap
//   swap_req_i/swap_ack_o  level request / one-cycle ack of shadow -> active
//   active_valid_o         set by the first completed swap
//   bias_o                 registered active bank, [K-1:0][WIDTH-1:0]

// One channel's shadow/active register pair.
module bias_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             swap,
  output logic [WIDTH-1:0] active
);
  logic [WIDTH-1:0] shadow;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow <= '0;
      active <= '0;
    end else begin
      // clr (load start) and wr (load word) are never high together.
      if (clr)     shadow <= '0;
      else if (wr) shadow <= wdata;
      // Shadow is sampled before any write of this edge; swap and clr/wr
      // happen in different states, so they never collide.
      if (swap)    active <= shadow;
    end
  end
endmodule

module bias_bank_ctrl #(
  parameter int K_CHANNELS = 4,
  parameter int WIDTH      = 32,
  parameter int CNT_W      = $clog2(K_CHANNELS + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 load_start_i,
  input  logic [CNT_W-1:0]                     load_count_i,
  input  logic                                 bias_valid_i,
  input  logic [WIDTH-1:0]                     bias_data_i,
  output logic                                 bias_ready_o,
  output logic                                 load_done_o,
  output logic                                 load_err_o,
  output logic                                 busy_o,
  input  logic                                 swap_req_i,
  output logic                                 swap_ack_o,
  output logic                                 active_valid_o,
  output logic [K_CHANNELS-1:0][WIDTH-1:0]     bias_o
);
  typedef enum logic [1:0] {IDLE, LOAD, LOADED} state_t;

  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K_CHANNELS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, ptr_q;
  logic             done_q, err_q, ack_q, aval_q;

  logic             start_ok, err_d, done_d, accept, swap_go;
  logic [CNT_W-1:0] cnt_clamp;

  // Oversized counts still load, just clamped to the bank size.
  assign cnt_clamp = (load_count_i > K_CNT) ? K_CNT : load_count_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;
    swap_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          if (load_count_i == '0) begin
            err_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            err_d    = (load_count_i > K_CNT);
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (bias_valid_i) begin
          accept = 1'b1;
          // ptr + 1 == cnt avoids the underflow of cnt - 1.
          if ((ptr_q + CNT_W'(1)) == cnt_q) begin
            done_d  = 1'b1;
            state_d = LOADED;
          end
        end
      end
      LOADED: begin
        // Swap has priority; a coincident load_start_i is simply dropped.
        if (swap_req_i) begin
          swap_go = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
      aval_q <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      ack_q  <= swap_go;
      if (swap_go) aval_q <= 1'b1;
      if (start_ok) begin
        cnt_q <= cnt_clamp;
        ptr_q <= '0;
      end else if (accept) begin
        ptr_q <= ptr_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < K_CHANNELS; i++) begin : g_lane
    bias_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (start_ok),
      .wr     (accept && (ptr_q == CNT_W'(i))),
      .wdata  (bias_data_i),
      .swap   (swap_go),
      .active (bias_o[i])
    );
  end

  // Outputs depend on registered state only.
  assign bias_ready_o   = (state_q == LOAD);
  assign busy_o         = (state_q != IDLE);
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign swap_ack_o     = ack_q;
  assign active_valid_o = aval_q;
endmodule

// File: tb/tb_bias_bank_ctrl.sv
// Directed + randomized bench for bias_bank_ctrl (K=4, WIDTH=32).
// The reference keeps the expected banks as plain arrays filled from the list
// of words sent per load.
module tb_bias_bank_ctrl;
  localparam int K = 4;
  localparam int W = 32;
  localparam int CW = $clog2(K + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load_start;
  logic [CW-1:0]       load_count;
  logic                bias_valid;
  logic [W-1:0]        bias_data;
  logic                bias_ready, load_done, load_err, busy;
  logic                swap_req, swap_ack, active_valid;
  logic [K-1:0][W-1:0] bias;

  bias_bank_ctrl #(.K_CHANNELS(K), .WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(load_start),
    .load_count_i(load_count), .bias_valid_i(bias_valid),
    .bias_data_i(bias_data), .bias_ready_o(bias_ready),
    .load_done_o(load_done), .load_err_o(load_err), .busy_o(busy),
    .swap_req_i(swap_req), .swap_ack_o(swap_ack),
    .active_valid_o(active_valid), .bias_o(bias)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state.
  logic [K-1:0][W-1:0] exp_active;
  logic [K-1:0][W-1:0] exp_shadow;
  logic                exp_aval;
  logic [W-1:0]        words [K];
  int                  gaps  [K];

  task automatic check(input string tag, input logic [K*W-1:0] obs,
                       input logic [K*W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue load_start with cnt and stream the first eff entries of words[]
  // (each preceded by gaps[i] idle cycles). Returns in the first LOADED
  // cycle, or in IDLE one cycle after an all-illegal start.
  task automatic run_load(input int cnt, input bit inject_start);
    int  eff;
    bit  err_exp;
    eff     = (cnt > K) ? K : cnt;
    err_exp = (cnt == 0) || (cnt > K);
    load_start = 1'b1;
    load_count = CW'(cnt);
    tick;
    load_start = 1'b0;
    check("load_err", 128'(load_err), 128'(err_exp));
    if (eff == 0) begin
      check("ready_cnt0", 128'(bias_ready), 128'(0));
      check("busy_cnt0", 128'(busy), 128'(0));
      tick;
      check("ready_cnt0_after", 128'(bias_ready), 128'(0));
      check("err_pulse", 128'(load_err), 128'(0));
      return;
    end
    exp_shadow = '0;
    for (int i = 0; i < eff; i++) exp_shadow[i] = words[i];
    for (int i = 0; i < eff; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bias_valid = 1'b0;
        check("ready_gap", 128'(bias_ready), 128'(1));
        check("bias_hold_gap", bias, exp_active);
        tick;
      end
      bias_valid = 1'b1;
      bias_data  = words[i];
      if (inject_start && i == 1) begin
        load_start = 1'b1;
        load_count = CW'(1);
      end
      check("ready_load", 128'(bias_ready), 128'(1));
      check("busy_load", 128'(busy), 128'(1));
      check("no_ack_load", 128'(swap_ack), 128'(0));
      check("bias_hold_load", bias, exp_active);
      tick;
      bias_valid = 1'b0;
      load_start = 1'b0;
    end
    check("load_done", 128'(load_done), 128'(1));
    check("ready_loaded", 128'(bias_ready), 128'(0));
    check("busy_loaded", 128'(busy), 128'(1));
    check("err_clear", 128'(load_err), 128'(0));
    check("bias_hold_done", bias, exp_active);
  endtask

  // Called in the first LOADED cycle; waits wait_n cycles then swaps.
  task automatic do_swap(input int wait_n);
    for (int w = 0; w < wait_n; w++) begin
      tick;
      check("done_pulse", 128'(load_done), 128'(0));
      check("busy_wait", 128'(busy), 128'(1));
      check("no_ack_wait", 128'(swap_ack), 128'(0));
    end
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    exp_active = exp_shadow;
    exp_aval   = 1'b1;
    check("swap_ack", 128'(swap_ack), 128'(1));
    check("bias_swap", bias, exp_active);
    check("aval_swap", 128'(active_valid), 128'(exp_aval));
    check("busy_swap", 128'(busy), 128'(0));
    tick;
    check("ack_pulse", 128'(swap_ack), 128'(0));
    check("bias_after", bias, exp_active);
  endtask

  task automatic rand_fill(input int maxgap);
    for (int i = 0; i < K; i++) begin
      words[i] = $urandom;
      gaps[i]  = $urandom_range(0, maxgap);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_bias"}, bias, 128'(0));
    check({tag, "_aval"}, 128'(active_valid), 128'(0));
    check({tag, "_ready"}, 128'(bias_ready), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(load_done), 128'(0));
    check({tag, "_err"}, 128'(load_err), 128'(0));
    check({tag, "_ack"}, 128'(swap_ack), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_count = '0; bias_valid = 1'b0;
    bias_data = '0; swap_req = 1'b0;
    exp_active = '0; exp_shadow = '0; exp_aval = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    check_reset_outs("reset");

    // Swap request with nothing loaded is never acked.
    swap_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("idle_swap_noack", 128'(swap_ack), 128'(0));
    end
    swap_req = 1'b0;

    // Full load and swap.
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    gaps  = '{0, 0, 0, 0};
    run_load(4, 1'b0);
    do_swap(0);
    check("full_pattern", bias, {32'h44, 32'h33, 32'h22, 32'h11});

    // Partial load with a 3-cycle stall, old bank held until swap.
    words = '{32'hFFFF_FFF0, 32'h7, 32'h0, 32'h0};
    gaps  = '{0, 3, 0, 0};
    run_load(2, 1'b0);
    do_swap(2);
    check("partial_pattern", bias, {32'h0, 32'h0, 32'h7, 32'hFFFF_FFF0});

    // Illegal counts.
    run_load(0, 1'b0);
    rand_fill(0);
    run_load(7, 1'b0);
    do_swap(1);

    // load_start during LOAD ignored.
    rand_fill(1);
    run_load(4, 1'b1);
    do_swap(0);

    // swap held from LOAD onward.
    rand_fill(1);
    swap_req = 1'b1;
    run_load(3, 1'b0);
    do_swap(0);

    // load_start together with swap in LOADED: swap wins.
    rand_fill(0);
    run_load(2, 1'b0);
    load_start = 1'b1; load_count = CW'(3); swap_req = 1'b1;
    tick;
    load_start = 1'b0; swap_req = 1'b0;
    exp_active = exp_shadow;
    check("conflict_ack", 128'(swap_ack), 128'(1));
    check("conflict_bias", bias, exp_active);
    check("conflict_busy", 128'(busy), 128'(0));
    check("conflict_ready", 128'(bias_ready), 128'(0));
    tick;
    check("conflict_ready2", 128'(bias_ready), 128'(0));
    check("conflict_busy2", 128'(busy), 128'(0));

    // Reset mid-load after 2 of 4 words.
    load_start = 1'b1; load_count = CW'(4);
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bias_valid = 1'b1; bias_data = $urandom;
      tick;
    end
    bias_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    exp_active = '0; exp_aval = 1'b0;
    check_reset_outs("midload_rst");
    rst_n = 1'b1;
    tick;
    words = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    gaps  = '{0, 0, 0, 0};
    run_load(4, 1'b0);
    check("post_rst_aval", 128'(active_valid), 128'(0));
    do_swap(0);

    // Randomized loads against the reference.
    for (int r = 0; r < 12; r++) begin
      int c;
      c = $urandom_range(0, 7);
      rand_fill(2);
      run_load(c, 1'b0);
      if (c != 0) do_swap($urandom_range(0, 2));
      check("rand_bias", bias, exp_active);
      check("rand_aval", 128'(active_valid), 128'(exp_aval));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
